// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI word slave.
package spi_pkg;
  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int SYNC_DEPTH = 2;
endpackage

// File: rtl/spi_slave_word_if.sv
// Word-side handshake bundle of the SPI slave: tx holding-register valid/ready, rx word pulse, status.
interface spi_slave_word_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             tx_underrun;
  logic             busy;

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, tx_underrun, busy
  );

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, tx_underrun, busy
  );
endinterface

// File: rtl/sync2.sv
// Multi-flop synchroniser for one asynchronous input; resets to RST_VAL.
module sync2
  import spi_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [SYNC_DEPTH-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= {SYNC_DEPTH{RST_VAL}};
    else        chain <= {chain[SYNC_DEPTH-2:0], d};
  end

  assign q = chain[SYNC_DEPTH-1];
endmodule

// File: rtl/spi_slave_word.sv
// SPI slave (modes 0-3) moving WIDTH-bit words; rx_valid pulses 1 clk after the synchronised sample edge (<=4 clk from pin).
// No rx backpressure; tx words enter a one-deep holding register through valid/ready.
module spi_slave_word
  import spi_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter bit CPOL  = 1'b0,
  parameter bit CPHA  = 1'b0
) (
  input  logic clk,
  input  logic rst_raw,
  input  logic sck,
  input  logic sdi,
  input  logic nss,
  output logic sdo,
  spi_slave_word_if.slave bus
);
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic sck_s, sdi_s, nss_s, sck_d;

  sync2 #(.RST_VAL(CPOL)) u_sync_sck (.clk(clk), .rst_n(rst_raw), .d(sck), .q(sck_s));
  sync2 #(.RST_VAL(1'b0)) u_sync_sdi (.clk(clk), .rst_n(rst_raw), .d(sdi), .q(sdi_s));
  sync2 #(.RST_VAL(1'b1)) u_sync_nss (.clk(clk), .rst_n(rst_raw), .d(nss), .q(nss_s));

  always_ff @(posedge clk or negedge rst_raw) begin
    if (!rst_raw) sck_d <= CPOL;
    else          sck_d <= sck_s;
  end

  logic lead, trail, sample_edge, shift_edge;
  assign lead        = (sck_d == CPOL) && (sck_s != CPOL);
  assign trail       = (sck_d != CPOL) && (sck_s == CPOL);
  assign sample_edge = CPHA ? trail : lead;
  assign shift_edge  = CPHA ? lead  : trail;

  state_t state, state_nxt;
  logic   frame_start, frame_end;

  always_ff @(posedge clk or negedge rst_raw) begin
    if (!rst_raw) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    case (state)
      IDLE: begin
        if (!nss_s) begin
          state_nxt   = ACTIVE;
          frame_start = 1'b1;
        end
      end
      ACTIVE: begin
        if (nss_s) begin
          state_nxt = IDLE;
          frame_end = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rx_sr, rx_next, tx_sr, hold_dat;
  logic             hold_vld, run, do_sample, do_shift, load, take;

  assign run       = (state == ACTIVE) && !nss_s;
  assign do_sample = run && sample_edge;
  assign do_shift  = run && shift_edge;
  // A shift edge seen with the counter at 0 is always a word boundary: the
  // first leading edge for CPHA=1, the trailing edge after the last sample for CPHA=0.
  assign load      = (!CPHA && frame_start) || (do_shift && (cnt == '0));
  // Bypass loads take tx_data straight into the shifter, so no handshake then.
  assign take      = bus.tx_valid && !hold_vld && !load;
  assign rx_next   = {rx_sr[WIDTH-2:0], sdi_s};

  always_ff @(posedge clk or negedge rst_raw) begin
    if (!rst_raw) begin
      cnt             <= '0;
      rx_sr           <= '0;
      tx_sr           <= '0;
      hold_vld        <= 1'b0;
      hold_dat        <= '0;
      bus.rx_data     <= '0;
      bus.rx_valid    <= 1'b0;
      bus.tx_underrun <= 1'b0;
    end else begin
      bus.rx_valid    <= 1'b0;
      bus.tx_underrun <= 1'b0;

      if (frame_end) begin
        cnt   <= '0;
        rx_sr <= '0;
      end else if (do_sample) begin
        rx_sr <= rx_next;
        if (cnt == LAST) begin
          cnt          <= '0;
          bus.rx_data  <= rx_next;
          bus.rx_valid <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      if (frame_end) begin
        tx_sr <= '0;
      end else if (load) begin
        if (hold_vld) begin
          tx_sr <= hold_dat;
        end else if (bus.tx_valid) begin
          tx_sr <= bus.tx_data;
        end else begin
          tx_sr           <= '0;
          bus.tx_underrun <= 1'b1;
        end
      end else if (do_shift) begin
        tx_sr <= {tx_sr[WIDTH-2:0], 1'b0};
      end

      if (load && hold_vld) begin
        hold_vld <= 1'b0;
      end else if (take) begin
        hold_vld <= 1'b1;
        hold_dat <= bus.tx_data;
      end
    end
  end

  assign bus.tx_ready = !hold_vld;
  assign bus.busy     = (state == ACTIVE);
  assign sdo          = (state == ACTIVE) && tx_sr[WIDTH-1];
endmodule

// File: tb/tb_spi_slave_word.sv
// Bench for spi_slave_word: three instances (mode 0 / mode 3 at 8 bits, mode 1 at 16 bits) driven by one SPI master model.
module tb_spi_slave_word;
  localparam int HALF = 8;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_raw, sck_drv, sdi_drv, nss_drv, tx_valid_drv;
  logic [31:0] tx_data_drv;
  int          sel;

  logic nss0, nss1, nss2, sdo0, sdo1, sdo2;
  logic cur_cpol, cur_cpha, cur_sdo, cur_rx_valid, cur_tx_ready, cur_underrun, cur_busy;
  logic [31:0] cur_rx_data;

  spi_slave_word_if #(.WIDTH(8))  if0 ();
  spi_slave_word_if #(.WIDTH(8))  if1 ();
  spi_slave_word_if #(.WIDTH(16)) if2 ();

  assign nss0 = (sel == 0) ? nss_drv : 1'b1;
  assign nss1 = (sel == 1) ? nss_drv : 1'b1;
  assign nss2 = (sel == 2) ? nss_drv : 1'b1;
  assign if0.tx_data  = tx_data_drv[7:0];
  assign if1.tx_data  = tx_data_drv[7:0];
  assign if2.tx_data  = tx_data_drv[15:0];
  assign if0.tx_valid = tx_valid_drv && (sel == 0);
  assign if1.tx_valid = tx_valid_drv && (sel == 1);
  assign if2.tx_valid = tx_valid_drv && (sel == 2);

  spi_slave_word #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b0)) u0 (
    .clk(clk), .rst_raw(rst_raw), .sck(sck_drv), .sdi(sdi_drv), .nss(nss0), .sdo(sdo0), .bus(if0));
  spi_slave_word #(.WIDTH(8), .CPOL(1'b1), .CPHA(1'b1)) u1 (
    .clk(clk), .rst_raw(rst_raw), .sck(sck_drv), .sdi(sdi_drv), .nss(nss1), .sdo(sdo1), .bus(if1));
  spi_slave_word #(.WIDTH(16), .CPOL(1'b0), .CPHA(1'b1)) u2 (
    .clk(clk), .rst_raw(rst_raw), .sck(sck_drv), .sdi(sdi_drv), .nss(nss2), .sdo(sdo2), .bus(if2));

  always_comb begin
    cur_cpol     = (sel == 1);
    cur_cpha     = (sel != 0);
    cur_sdo      = sdo0;
    cur_rx_valid = if0.rx_valid;
    cur_rx_data  = {24'b0, if0.rx_data};
    cur_tx_ready = if0.tx_ready;
    cur_underrun = if0.tx_underrun;
    cur_busy     = if0.busy;
    if (sel == 1) begin
      cur_sdo      = sdo1;
      cur_rx_valid = if1.rx_valid;
      cur_rx_data  = {24'b0, if1.rx_data};
      cur_tx_ready = if1.tx_ready;
      cur_underrun = if1.tx_underrun;
      cur_busy     = if1.busy;
    end else if (sel == 2) begin
      cur_sdo      = sdo2;
      cur_rx_valid = if2.rx_valid;
      cur_rx_data  = {16'b0, if2.rx_data};
      cur_tx_ready = if2.tx_ready;
      cur_underrun = if2.tx_underrun;
      cur_busy     = if2.busy;
    end
  end

  int          n_tests, n_fail, un_cnt;
  logic [31:0] exp_q[$];
  time         last_sample_t, last_rxv_t;

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, got, exp, $time);
    end
  endfunction

  // Bit-level master; pushes the expected rx word as soon as its last sample edge is driven.
  task automatic master_word(input logic [31:0] mosi, input int width, input int nbits,
                             input int half, output logic [31:0] miso);
    miso = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!cur_cpha) begin
        sdi_drv = mosi[width-1-i];
        repeat (half) @(negedge clk);
        miso    = {miso[30:0], cur_sdo};
        sck_drv = ~cur_cpol;
        last_sample_t = $time;
        if (i == width - 1) exp_q.push_back(mosi);
        repeat (half) @(negedge clk);
        sck_drv = cur_cpol;
      end else begin
        sck_drv = ~cur_cpol;
        sdi_drv = mosi[width-1-i];
        repeat (half) @(negedge clk);
        miso    = {miso[30:0], cur_sdo};
        sck_drv = cur_cpol;
        last_sample_t = $time;
        if (i == width - 1) exp_q.push_back(mosi);
        repeat (half) @(negedge clk);
      end
    end
  endtask

  task automatic push_tx(input logic [31:0] d);
    int w;
    w = 0;
    while (!cur_tx_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("tx_ready_wait", 32'(cur_tx_ready), 32'd1);
    tx_data_drv  = d;
    tx_valid_drv = 1'b1;
    @(negedge clk);
    tx_valid_drv = 1'b0;
  endtask

  task automatic select(input int s);
    sel     = s;
    sck_drv = (s == 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic end_frame();
    repeat (HALF) @(negedge clk);
    nss_drv = 1'b1;
    repeat (12) @(negedge clk);
    check("rx_count", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  typedef struct {
    int          sel;
    int          width;
    logic [31:0] mosi;
    logic [31:0] tx;
    logic [31:0] exp_miso;
  } vec_t;

  vec_t        vecs[4];
  logic [31:0] miso, miso2;

  initial begin
    vecs[0] = '{0, 8,  32'h3C,   32'hA5,   32'hA5};
    vecs[1] = '{0, 8,  32'hC3,   32'h5A,   32'h5A};
    vecs[2] = '{1, 8,  32'h96,   32'h69,   32'h69};
    vecs[3] = '{2, 16, 32'h1234, 32'hCAFE, 32'hCAFE};

    n_tests = 0; n_fail = 0; un_cnt = 0;
    sel = 0; rst_raw = 1'b0; sck_drv = 1'b0; sdi_drv = 1'b0; nss_drv = 1'b1;
    tx_valid_drv = 1'b0; tx_data_drv = '0;
    last_sample_t = 0; last_rxv_t = 0;

    fork
      forever begin
        @(negedge clk);
        if (cur_underrun) un_cnt++;
        if (cur_rx_valid) begin
          last_rxv_t = $time;
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rx_unexpected: rx_valid with rx_data %h, required no rx_valid (t=%0t)",
                     cur_rx_data, $time);
          end else begin
            check("rx_data", cur_rx_data, exp_q.pop_front());
          end
        end
      end
    join_none

    #3;
    check("rst_rx_data",  cur_rx_data, 32'd0);
    check("rst_rx_valid", 32'(cur_rx_valid), 32'd0);
    check("rst_tx_ready", 32'(cur_tx_ready), 32'd1);
    check("rst_underrun", 32'(cur_underrun), 32'd0);
    check("rst_busy",     32'(cur_busy), 32'd0);
    check("rst_sdo",      32'(cur_sdo), 32'd0);
    repeat (3) @(negedge clk);
    rst_raw = 1'b1;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      select(vecs[v].sel);
      push_tx(vecs[v].tx);
      check("tx_ready_full", 32'(cur_tx_ready), 32'd0);
      nss_drv = 1'b0;
      repeat (8) @(negedge clk);
      if (!cur_cpha) check("tx_ready_nss_fall", 32'(cur_tx_ready), 32'd1);
      check("busy_frame", 32'(cur_busy), 32'd1);
      master_word(vecs[v].mosi, vecs[v].width, vecs[v].width, HALF, miso);
      end_frame();
      check("miso_vec", miso, vecs[v].exp_miso);
      check("busy_idle", 32'(cur_busy), 32'd0);
    end

    // Mode 3, two words in one frame.
    select(1);
    push_tx(32'h55);
    un_cnt = 0;
    nss_drv = 1'b0;
    repeat (8) @(negedge clk);
    master_word(32'h12, 8, 8, HALF, miso);
    push_tx(32'hAA);
    master_word(32'h34, 8, 8, HALF, miso2);
    end_frame();
    check("miso_w0", miso, 32'h55);
    check("miso_w1", miso2, 32'hAA);
    check("underrun_2word", 32'(un_cnt), 32'd0);
    check("rx_data_w1", cur_rx_data, 32'h34);

    // Empty holding register at the load point.
    un_cnt = 0;
    nss_drv = 1'b0;
    repeat (8) @(negedge clk);
    master_word(32'h5A, 8, 8, HALF, miso);
    end_frame();
    check("miso_underrun", miso, 32'h00);
    check("underrun_pulses", 32'(un_cnt), 32'd1);

    // Bypass: tx_valid lands exactly in the nss-fall load cycle of mode 0.
    select(0);
    un_cnt = 0;
    nss_drv = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tx_data_drv  = 32'h77;
    tx_valid_drv = 1'b1;
    @(negedge clk);
    tx_valid_drv = 1'b0;
    check("bypass_no_underrun", 32'(un_cnt), 32'd0);
    check("bypass_tx_ready", 32'(cur_tx_ready), 32'd1);
    repeat (5) @(negedge clk);
    master_word(32'h11, 8, 8, HALF, miso);
    end_frame();
    check("miso_bypass", miso, 32'h77);

    // Abort after 5 of 8 bits.
    nss_drv = 1'b0;
    repeat (8) @(negedge clk);
    master_word(32'hAB, 8, 5, HALF, miso);
    end_frame();
    check("abort_rx_data", cur_rx_data, 32'h11);
    nss_drv = 1'b0;
    repeat (8) @(negedge clk);
    master_word(32'hF0, 8, 8, HALF, miso);
    end_frame();
    check("after_abort_rx", cur_rx_data, 32'hF0);

    // Reset mid-word.
    nss_drv = 1'b0;
    repeat (8) @(negedge clk);
    push_tx(32'h99);
    master_word(32'hC5, 8, 3, HALF, miso);
    rst_raw = 1'b0;
    #1;
    check("mid_rst_rx_data",  cur_rx_data, 32'd0);
    check("mid_rst_rx_valid", 32'(cur_rx_valid), 32'd0);
    check("mid_rst_tx_ready", 32'(cur_tx_ready), 32'd1);
    check("mid_rst_underrun", 32'(cur_underrun), 32'd0);
    check("mid_rst_busy",     32'(cur_busy), 32'd0);
    check("mid_rst_sdo",      32'(cur_sdo), 32'd0);
    nss_drv = 1'b1;
    sck_drv = 1'b0;
    repeat (3) @(negedge clk);
    rst_raw = 1'b1;
    repeat (4) @(negedge clk);
    push_tx(32'h42);
    nss_drv = 1'b0;
    repeat (8) @(negedge clk);
    master_word(32'h81, 8, 8, HALF, miso);
    end_frame();
    check("post_rst_rx", cur_rx_data, 32'h81);
    check("post_rst_miso", miso, 32'h42);

    // 16-bit mode 1 at clk = 4x sck.
    select(2);
    last_rxv_t = 0;
    nss_drv = 1'b0;
    repeat (8) @(negedge clk);
    master_word(32'hBEEF, 16, 16, 2, miso);
    end_frame();
    check("fast_rx", cur_rx_data, 32'hBEEF);
    check("fast_rxv_latency",
          32'((last_rxv_t > last_sample_t) && (last_rxv_t - last_sample_t <= 40)), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_slave_word.md
SPI_SLAVE_WORD -- requirements
Module: spi_slave_word

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bits per SPI word (legal 4..32).
REQ-002 SHALL have parameter CPOL, default 0, SCK idle level.
REQ-003 SHALL have parameter CPHA, default 0: 0 = sample on leading edge; 1 = sample on trailing edge.
REQ-004 SHALL have port clk, input, 1, system clock; sole clock of the block.
REQ-005 SHALL have port rst_raw, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port sck, input, 1, SPI clock from master, asynchronous to clk.
REQ-007 SHALL have port sdi, input, 1, master-out data, asynchronous.
REQ-008 SHALL have port nss, input, 1, slave select, active-low, asynchronous.
REQ-009 SHALL have port sdo, output, 1, slave-out data, MSB first.
REQ-010 SHALL have port tx_data, input, WIDTH, word to transmit.
REQ-011 SHALL have port tx_valid, input, 1, tx_data offered.
REQ-012 SHALL have port tx_ready, output, 1, holding register empty.
REQ-013 SHALL have port rx_data, output, WIDTH, last complete received word.
REQ-014 SHALL have port rx_valid, output, 1, one-clk pulse when rx_data updates.
REQ-015 SHALL have port tx_underrun, output, 1, one-clk pulse when a word loads with holding register empty.
REQ-016 SHALL have port busy, output, 1, frame active (synchronised nss low).

Function
REQ-017 sck, sdi and nss SHALL each pass through a 2-flop synchroniser in clk. Edges SHALL be detected on the synchronised sck against a third registered copy. clk SHALL be at least 4x the sck frequency.
REQ-018 Leading edge = synchronised sck leaving CPOL level; trailing edge = returning to it.
REQ-019 State machine SHALL have two states: IDLE (synchronised nss high) and ACTIVE. IDLE->ACTIVE on synchronised nss fall; ACTIVE->IDLE on synchronised nss rise.
REQ-020 On the sample edge in ACTIVE: shift synchronised sdi into the rx shift register LSB; increment the bit counter (0..WIDTH-1).
REQ-021 When the counter wraps from WIDTH-1 to 0: rx_data SHALL take the full word and rx_valid SHALL pulse, 1 clk after that sample edge. Pin-to-rx_valid latency is at most 4 clk.
REQ-022 Words SHALL repeat within a frame without nss toggling. The counter wraps and each word produces its own rx_valid.
REQ-023 Shift-edge behaviour: on the edge opposite the sample edge, sdo SHALL advance to the next bit. For CPHA=0, the word boundary load SHALL occur on the last trailing edge of the word.
REQ-024 Load points: nss fall (CPHA=0, so bit MSB is on sdo before the first leading edge); first leading edge (CPHA=1); each word boundary.
REQ-025 At a load point, the tx shift register SHALL take the holding register and set tx_ready=1.
REQ-026 If the holding register is empty at a load point, zeros SHALL load and tx_underrun SHALL pulse.
REQ-027 Bypass: if tx_valid is high in the load cycle while the holding register is empty, tx_data SHALL load directly, with no underrun.
REQ-028 Handshake: a word transfers on the clk edge where tx_valid && tx_ready; tx_ready SHALL drop the next cycle. Holding-register contents SHALL persist across frames.
REQ-029 nss rise mid-word: the partial rx word SHALL be discarded with no rx_valid. The counter SHALL clear, and the tx shift register and its word SHALL be dropped.
REQ-030 In IDLE: sdo SHALL be 0 and sck edges SHALL be ignored.
REQ-031 rx_valid has no backpressure. Consumers SHALL capture within WIDTH sck periods.

Reset
REQ-032 While rst_raw is low, all state SHALL clear asynchronously: state=IDLE, counter=0, rx_data=0, rx_valid=0, tx_underrun=0, busy=0, sdo=0, tx_ready=1, holding register empty, synchronisers at idle levels (sck=CPOL, nss=1).
REQ-033 Reset mid-frame SHALL abort the frame; after release, the block waits for a fresh nss fall before any transfer.

Structure
REQ-034 Package spi_pkg SHALL hold the state enum (IDLE, ACTIVE) and the synchroniser depth constant.
REQ-035 Sub-module sync2 (2-flop synchroniser, async active-low reset, parametrised reset value) SHALL be instantiated three times.

Verification
REQ-036 Mode 0, WIDTH=8: preload tx 0xA5; master sends 0x3C -> rx_data=0x3C with one rx_valid; master receives 0xA5; tx_ready re-asserts at nss fall.
REQ-037 Mode 3 (CPOL=1, CPHA=1), WIDTH=8: 2-word frame, master sends 0x12 then 0x34, tx holds 0x55 then 0xAA -> two rx_valid pulses with 0x12, 0x34; master receives 0x55, 0xAA.
REQ-038 Empty holding register at a load point -> tx_underrun single pulse, master receives 0x00. tx_valid asserted in the load cycle with 0x77 -> 0x77 sent, no underrun.
REQ-039 nss raised after 5 of 8 bits -> no rx_valid, rx_data unchanged. Next full frame 0xF0 -> rx_data=0xF0.
REQ-040 rst_raw pulsed low mid-word -> all outputs at reset values immediately; subsequent frame 0x81 received correctly.
REQ-041 WIDTH=16, mode 1, clk=4x sck: send 0xBEEF -> rx_data=0xBEEF; rx_valid within 4 clk of final sample edge.
